// File: rtl/wfg_mem_pkg.sv
// Shared types and constants for the Wishbone-to-waveform-SRAM bridge.
// The window is 4 KB, and word-address bit 9 selects between the two 512-word macros.
package wfg_mem_pkg;

    localparam int WB_DW     = 32;
    localparam int WB_SW     = WB_DW / 8;
    localparam int MEM_WORDS = 512;
    localparam int MEM_AW    = $clog2(MEM_WORDS);
    localparam int WIN_BYTES = 4096;
    localparam int WIN_AW    = $clog2(WIN_BYTES);
    localparam int BANK_BIT  = 9;
    localparam int LAT_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    typedef struct packed {
        logic              csb;
        logic              web;
        logic [WB_SW-1:0]  wmask;
        logic [MEM_AW-1:0] addr;
        logic [WB_DW-1:0]  din;
    } mem_ctl_t;

    localparam mem_ctl_t MEM_CTL_RST = '{
        csb:   1'b1,
        web:   1'b1,
        wmask: {WB_SW{1'b0}},
        addr:  {MEM_AW{1'b0}},
        din:   {WB_DW{1'b0}}
    };

    function automatic logic win_hit(input logic [31:0] adr, input logic [31:0] base);
        return (adr >> WIN_AW) == (base >> WIN_AW);
    endfunction

endpackage

// File: rtl/wfg_mem_port_mux.sv
// Bank steering for port 0 of the two pattern SRAMs: computes each macro's next control word
// and selects the read data of the bank that was addressed.
module wfg_mem_port_mux
    import wfg_mem_pkg::*;
(
    input  logic              load,
    input  logic              bank,
    input  logic              we,
    input  logic [WB_SW-1:0]  sel,
    input  logic [MEM_AW-1:0] addr,
    input  logic [WB_DW-1:0]  din,
    input  mem_ctl_t          cur0,
    input  mem_ctl_t          cur1,
    output mem_ctl_t          nxt0,
    output mem_ctl_t          nxt1,
    input  logic              rd_bank,
    input  logic [WB_DW-1:0]  dout0,
    input  logic [WB_DW-1:0]  dout1,
    output logic [WB_DW-1:0]  dout
);

    mem_ctl_t issue_s;

    // Next control word per bank: the addressed bank gets the request; idle banks deselect but keep their data lines.
    always_comb begin
        issue_s.csb   = 1'b0;
        issue_s.web   = ~we;
        issue_s.wmask = we ? sel : {WB_SW{1'b0}};
        issue_s.addr  = addr;
        issue_s.din   = din;

        nxt0     = cur0;
        nxt0.csb = 1'b1;
        nxt0.web = 1'b1;
        nxt1     = cur1;
        nxt1.csb = 1'b1;
        nxt1.web = 1'b1;

        case ({load, bank})
            2'b10:   nxt0 = issue_s;
            2'b11:   nxt1 = issue_s;
            default: begin end
        endcase
    end

    // Read data of the bank that was captured at issue.
    always_comb begin
        if (rd_bank) begin
            dout = dout1;
        end else begin
            dout = dout0;
        end
    end

endmodule

// File: rtl/wfg_mem_wb_bridge.sv
// Wishbone classic slave giving the management SoC access to port 0 of the two waveform SRAMs.
// Every output comes straight from a register, and the read data is zero outside the ack cycle so it can be OR-merged.
module wfg_mem_wb_bridge
    import wfg_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h3010_0000,
    parameter int          READ_LATENCY = 2
) (
    input  logic              io_wbs_clk,
    input  logic              io_wbs_rst_n,
    input  logic [31:0]       io_wbs_adr,
    input  logic [WB_DW-1:0]  io_wbs_datwr,
    input  logic [WB_SW-1:0]  io_wbs_sel,
    input  logic              io_wbs_we,
    input  logic              io_wbs_stb,
    input  logic              io_wbs_cyc,
    output logic              io_wbs_ack,
    output logic [WB_DW-1:0]  io_wbs_datrd,
    output logic              csb0_mem0,
    output logic              csb0_mem1,
    output logic              web0_mem0,
    output logic              web0_mem1,
    output logic [WB_SW-1:0]  wmask0_mem0,
    output logic [WB_SW-1:0]  wmask0_mem1,
    output logic [MEM_AW-1:0] addr0_mem0,
    output logic [MEM_AW-1:0] addr0_mem1,
    output logic [WB_DW-1:0]  din0_mem0,
    output logic [WB_DW-1:0]  din0_mem1,
    input  logic [WB_DW-1:0]  dout0_mem0,
    input  logic [WB_DW-1:0]  dout0_mem1
);

    state_t            state_r, state_s;
    logic [LAT_W-1:0]  lat_r, lat_s;
    logic              we_r, bank_r;
    logic              hit_s, load_s, ack_s;
    logic [WB_DW-1:0]  datrd_s, dout_s;
    logic [WIN_AW-3:0] word_s;
    mem_ctl_t          ctl0_r, ctl1_r, nxt0_s, nxt1_s;
    logic              unused_s;

    // Byte offset within a word plays no part in addressing.
    assign unused_s = ^io_wbs_adr[1:0];
    assign word_s   = io_wbs_adr[WIN_AW-1:2];
    assign hit_s    = win_hit(io_wbs_adr, BASE_ADDR) & io_wbs_stb & io_wbs_cyc;

    wfg_mem_port_mux u_port_mux (
        .load    (load_s),
        .bank    (word_s[BANK_BIT]),
        .we      (io_wbs_we),
        .sel     (io_wbs_sel),
        .addr    (word_s[MEM_AW-1:0]),
        .din     (io_wbs_datwr),
        .cur0    (ctl0_r),
        .cur1    (ctl1_r),
        .nxt0    (nxt0_s),
        .nxt1    (nxt1_s),
        .rd_bank (bank_r),
        .dout0   (dout0_mem0),
        .dout1   (dout0_mem1),
        .dout    (dout_s)
    );

    assign csb0_mem0   = ctl0_r.csb;
    assign web0_mem0   = ctl0_r.web;
    assign wmask0_mem0 = ctl0_r.wmask;
    assign addr0_mem0  = ctl0_r.addr;
    assign din0_mem0   = ctl0_r.din;
    assign csb0_mem1   = ctl1_r.csb;
    assign web0_mem1   = ctl1_r.web;
    assign wmask0_mem1 = ctl1_r.wmask;
    assign addr0_mem1  = ctl1_r.addr;
    assign din0_mem1   = ctl1_r.din;

    // Transfer sequencing: decides the next state, when the macro is loaded, and when ack and read data are produced.
    always_comb begin
        state_s = state_r;
        lat_s   = lat_r;
        load_s  = 1'b0;
        ack_s   = 1'b0;
        datrd_s = {WB_DW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    load_s  = 1'b1;
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!io_wbs_cyc) begin
                    state_s = ST_IDLE;
                end else if (we_r) begin
                    ack_s   = 1'b1;
                    state_s = ST_ACK;
                end else if (READ_LATENCY == 1) begin
                    ack_s   = 1'b1;
                    datrd_s = dout_s;
                    state_s = ST_ACK;
                end else begin
                    lat_s   = LAT_W'(READ_LATENCY - 1);
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!io_wbs_cyc) begin
                    state_s = ST_IDLE;
                end else if (lat_r == {LAT_W{1'b0}}) begin
                    ack_s   = 1'b1;
                    datrd_s = dout_s;
                    state_s = ST_ACK;
                end else begin
                    lat_s = lat_r - 2'd1;
                end
            end
            ST_ACK:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // All state and every output register; reset drops any in-flight transfer.
    always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
        if (!io_wbs_rst_n) begin
            state_r      <= ST_IDLE;
            lat_r        <= {LAT_W{1'b0}};
            we_r         <= 1'b0;
            bank_r       <= 1'b0;
            io_wbs_ack   <= 1'b0;
            io_wbs_datrd <= {WB_DW{1'b0}};
            ctl0_r       <= MEM_CTL_RST;
            ctl1_r       <= MEM_CTL_RST;
        end else begin
            state_r      <= state_s;
            lat_r        <= lat_s;
            io_wbs_ack   <= ack_s;
            io_wbs_datrd <= datrd_s;
            ctl0_r       <= nxt0_s;
            ctl1_r       <= nxt1_s;
            if (load_s) begin
                we_r   <= io_wbs_we;
                bank_r <= word_s[BANK_BIT];
            end
        end
    end

endmodule

// File: tb/tb_wfg_mem_wb_bridge.sv
// Directed bench for wfg_mem_wb_bridge: behavioural SRAM models on both ports, and a scoreboard
// queue of expected read data and ack cycle that an independent monitor drains.
module tb_wfg_mem_wb_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr, datwr;
    logic [3:0]  sel;
    logic        we, stb, cyc;
    logic        ack;
    logic [31:0] datrd;
    logic        csb0_mem0, csb0_mem1, web0_mem0, web0_mem1;
    logic [3:0]  wmask0_mem0, wmask0_mem1;
    logic [8:0]  addr0_mem0, addr0_mem1;
    logic [31:0] din0_mem0, din0_mem1, dout0_mem0, dout0_mem1;

    logic [31:0] mem0 [0:511];
    logic [31:0] mem1 [0:511];

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc_cnt = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wfg_mem_wb_bridge #(
        .BASE_ADDR    (32'h3010_0000),
        .READ_LATENCY (2)
    ) dut (
        .io_wbs_clk   (clk),
        .io_wbs_rst_n (rst_n),
        .io_wbs_adr   (adr),
        .io_wbs_datwr (datwr),
        .io_wbs_sel   (sel),
        .io_wbs_we    (we),
        .io_wbs_stb   (stb),
        .io_wbs_cyc   (cyc),
        .io_wbs_ack   (ack),
        .io_wbs_datrd (datrd),
        .csb0_mem0    (csb0_mem0),
        .csb0_mem1    (csb0_mem1),
        .web0_mem0    (web0_mem0),
        .web0_mem1    (web0_mem1),
        .wmask0_mem0  (wmask0_mem0),
        .wmask0_mem1  (wmask0_mem1),
        .addr0_mem0   (addr0_mem0),
        .addr0_mem1   (addr0_mem1),
        .din0_mem0    (din0_mem0),
        .din0_mem1    (din0_mem1),
        .dout0_mem0   (dout0_mem0),
        .dout0_mem1   (dout0_mem1)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // SRAM macro behaviour: write with byte mask, or a registered read.
    always @(posedge clk) begin
        if (!csb0_mem0) begin
            if (!web0_mem0) mem0[addr0_mem0] <= merge(mem0[addr0_mem0], din0_mem0, wmask0_mem0);
            else            dout0_mem0 <= mem0[addr0_mem0];
        end
        if (!csb0_mem1) begin
            if (!web0_mem1) mem1[addr0_mem1] <= merge(mem1[addr0_mem1], din0_mem1, wmask0_mem1);
            else            dout0_mem1 <= mem1[addr0_mem1];
        end
    end

    // Monitor: every ack consumes one expected entry; outside ack the read bus must be zero.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (ack) begin
            if (q.size() == 0) begin
                check("unexpected_ack", {31'b0, ack}, 32'd0);
            end else begin
                e = q.pop_front();
                check("ack_data", datrd, e.data);
                check("ack_cycle", cyc_cnt, e.cyc);
            end
        end else begin
            check("datrd_idle_zero", datrd, 32'h0);
        end
    end

    task automatic wb_start(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, input logic expect_ack,
                            input logic [31:0] exp_data, input int lat);
        @(posedge clk);
        #1;
        adr = a; we = w; datwr = d; sel = s; stb = 1'b1; cyc = 1'b1;
        if (expect_ack) q.push_back('{exp_data, cyc_cnt + lat});
    endtask

    task automatic wb_finish();
        for (int i = 0; i < 30; i++) begin
            if (ack) break;
            @(negedge clk);
        end
        if (!ack) check("ack_timeout", {31'b0, ack}, 32'd1);
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_start(a, 1'b1, d, s, 1'b1, 32'h0, 2);
        wb_finish();
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] exp_data);
        wb_start(a, 1'b0, 32'h0, 4'h0, 1'b1, exp_data, 4);
        wb_finish();
    endtask

    initial begin
        rst_n = 1'b0;
        adr = 32'h0; datwr = 32'h0; sel = 4'h0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_csb", {30'b0, csb0_mem1, csb0_mem0}, 32'd3);
        check("rst_web", {30'b0, web0_mem1, web0_mem0}, 32'd3);
        check("rst_wmask", {24'b0, wmask0_mem1, wmask0_mem0}, 32'h0);
        check("rst_addr", {14'b0, addr0_mem1, addr0_mem0}, 32'h0);
        check("rst_din", din0_mem0 | din0_mem1, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Write word 1 of mem0 and watch the one-cycle macro access.
        wb_start(32'h3010_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 2);
        repeat (2) @(negedge clk);
        check("w1_csb0", {31'b0, csb0_mem0}, 32'd0);
        check("w1_web0", {31'b0, web0_mem0}, 32'd0);
        check("w1_addr0", {23'b0, addr0_mem0}, 32'd1);
        check("w1_wmask0", {28'b0, wmask0_mem0}, 32'hF);
        check("w1_din0", din0_mem0, 32'hDEAD_BEEF);
        check("w1_csb1_idle", {31'b0, csb0_mem1}, 32'd1);
        @(negedge clk);
        check("w1_csb0_release", {30'b0, web0_mem0, csb0_mem0}, 32'd3);
        wb_finish();
        wb_read(32'h3010_0004, 32'hDEAD_BEEF);
        check("w1_mem1_untouched", mem1[1], 32'h0);

        // First word of mem1 with a partial byte mask.
        wb_start(32'h3010_0800, 1'b1, 32'h1234_5678, 4'h3, 1'b1, 32'h0, 2);
        repeat (2) @(negedge clk);
        check("w2_csb1", {31'b0, csb0_mem1}, 32'd0);
        check("w2_addr1", {23'b0, addr0_mem1}, 32'd0);
        check("w2_wmask1", {28'b0, wmask0_mem1}, 32'h3);
        check("w2_csb0_idle", {31'b0, csb0_mem0}, 32'd1);
        wb_finish();
        wb_read(32'h3010_0800, 32'h0000_5678);

        // Last word of mem0 stays in mem0.
        wb_start(32'h3010_07FC, 1'b1, 32'hA5A5_5A5A, 4'hF, 1'b1, 32'h0, 2);
        repeat (2) @(negedge clk);
        check("w3_addr0_511", {23'b0, addr0_mem0}, 32'd511);
        check("w3_bank_sel", {30'b0, csb0_mem1, csb0_mem0}, 32'd2);
        wb_finish();
        wb_read(32'h3010_07FC, 32'hA5A5_5A5A);

        // A write with no byte selects is acked but changes nothing.
        wb_write(32'h3010_0004, 32'hFFFF_FFFF, 4'h0);
        wb_read(32'h3010_0004, 32'hDEAD_BEEF);

        // Outside the window: no chip select, and the monitor rejects any ack.
        wb_start(32'h3000_0010, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("nohit_csb", {30'b0, csb0_mem1, csb0_mem0}, 32'd3);
        end
        @(posedge clk);
        #1 stb = 1'b0; cyc = 1'b0;

        // Abort a read while it is waiting, then confirm a normal write still goes through.
        wb_start(32'h3010_0004, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1 stb = 1'b0; cyc = 1'b0;
        repeat (6) @(negedge clk);
        wb_write(32'h3010_0008, 32'h0BAD_F00D, 4'hF);
        wb_read(32'h3010_0008, 32'h0BAD_F00D);

        // Reset in the middle of a read's wait phase.
        wb_start(32'h3010_0004, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        stb = 1'b0; cyc = 1'b0;
        #1;
        check("midrst_ack_datrd", {31'b0, ack} | datrd, 32'h0);
        check("midrst_csb_web", {28'b0, csb0_mem1, csb0_mem0, web0_mem1, web0_mem0}, 32'hF);
        check("midrst_addr_mask", {6'b0, addr0_mem1, addr0_mem0, wmask0_mem1, wmask0_mem0}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wb_read(32'h3010_0004, 32'hDEAD_BEEF);

        repeat (5) @(negedge clk);
        check("scoreboard_drain", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
